// File: rtl/asi_ram_arb_if.sv
// Requester-side and RAM-side signal bundle for the asi_ram_arb RAM port arbiter.
interface asi_ram_arb_if #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned AXI_DW = 128,
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned WSTRBW = AXI_DW/8
);
  logic [NCH-1:0]        req;
  logic [NCH-1:0]        en;
  logic [NCH-1:0]        we;
  logic [NCH-1:0]        last;
  logic [NCH*AXI_AW-1:0] addr;
  logic [NCH*AXI_DW-1:0] wdata;
  logic [NCH*WSTRBW-1:0] wstrb;
  logic [NCH-1:0]        grant;
  logic [NCH-1:0]        rvalid;
  logic [AXI_DW-1:0]     rdata;
  logic                  arb_err;
  logic                  RAM_CEN;
  logic [WSTRBW-1:0]     RAM_WEN;
  logic [AXI_AW-1:0]     RAM_A;
  logic [AXI_DW-1:0]     RAM_D;
  logic [AXI_DW-1:0]     RAM_Q;

  modport slave (
    input  req, en, we, last, addr, wdata, wstrb, RAM_Q,
    output grant, rvalid, rdata, arb_err, RAM_CEN, RAM_WEN, RAM_A, RAM_D
  );

  modport master (
    output req, en, we, last, addr, wdata, wstrb, RAM_Q,
    input  grant, rvalid, rdata, arb_err, RAM_CEN, RAM_WEN, RAM_A, RAM_D
  );
endinterface

// File: rtl/asi_ram_arb.sv
// N-channel burst-tenure arbiter and port mux for one single-port RAM, with
// tagged read-data return after RAM_RL cycles.
module asi_ram_arb #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned AXI_DW     = 128,
  parameter int unsigned AXI_AW     = 32,
  parameter int unsigned WSTRBW     = AXI_DW/8,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned MAX_BURSTS = 0,
  parameter int unsigned RAM_RL     = 1
) (
  input  logic         usr_clk,
  input  logic         usr_reset_n,
  asi_ram_arb_if.slave bus
);
  localparam int unsigned OW = $clog2(NCH);
  localparam int unsigned CW = (MAX_BURSTS > 1) ? $clog2(MAX_BURSTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     own_q, own_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NCH-1:0]    grant_q, grant_d;
  logic              arb_err_q, arb_err_d;
  logic [NCH-1:0]    rd_pipe_q [RAM_RL];
  logic [NCH-1:0]    rd_in;

  logic              sel_en, sel_we, sel_last, acc;
  logic [AXI_AW-1:0] sel_addr;
  logic [AXI_DW-1:0] sel_wdata;
  logic [WSTRBW-1:0] sel_wstrb;

  logic [OW-1:0]     fix_win, oth_win, rr_win, win;
  logic              fix_found, oth_found, rr_found, arb_ev;
  int unsigned       idx;

  // Owner's access fields selected by the owner register
  always_comb begin
    sel_en    = 1'b0;
    sel_we    = 1'b0;
    sel_last  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NCH; i++) begin
      if (own_q == OW'(i)) begin
        sel_en    = bus.en[i];
        sel_we    = bus.we[i];
        sel_last  = bus.last[i];
        sel_addr  = bus.addr[i*AXI_AW +: AXI_AW];
        sel_wdata = bus.wdata[i*AXI_DW +: AXI_DW];
        sel_wstrb = bus.wstrb[i*WSTRBW +: WSTRBW];
      end
    end
  end

  assign acc = (|grant_q) & sel_en;

  // Candidate winners: lowest index, lowest non-owner, and round-robin from ptr
  always_comb begin
    fix_win   = '0;
    fix_found = 1'b0;
    oth_win   = '0;
    oth_found = 1'b0;
    rr_win    = '0;
    rr_found  = 1'b0;
    idx       = 0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.req[i] && !fix_found) begin
        fix_win   = OW'(i);
        fix_found = 1'b1;
      end
      if (bus.req[i] && (own_q != OW'(i)) && !oth_found) begin
        oth_win   = OW'(i);
        oth_found = 1'b1;
      end
    end
    for (int k = 0; k < NCH; k++) begin
      idx = 32'(ptr_q) + 32'(k);
      if (idx >= NCH) idx = idx - NCH;
      if (bus.req[OW'(idx)] && !rr_found) begin
        rr_win   = OW'(idx);
        rr_found = 1'b1;
      end
    end
    win = fix_win;
    if (ARB_MODE == 1) begin
      win = rr_win;
    end else if ((MAX_BURSTS > 0) && (state_q == BUSY) && (fix_win == own_q) &&
                 (cnt_q == CW'(MAX_BURSTS - 1)) && oth_found) begin
      win = oth_win;
    end
  end

  // Tenure FSM: re-arbitrate in IDLE or on the owner's last access
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    arb_ev    = (state_q == IDLE) || (acc && sel_last);
    if (arb_ev) begin
      if (|bus.req) begin
        state_d = BUSY;
        own_d   = win;
        ptr_d   = (win == OW'(NCH - 1)) ? '0 : OW'(win + OW'(1));
        if ((MAX_BURSTS > 0) && (state_q == BUSY) && (win == own_q))
          cnt_d = (cnt_q == CW'(MAX_BURSTS - 1)) ? cnt_q : CW'(cnt_q + CW'(1));
        else
          cnt_d = '0;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
    grant_d   = (state_d == BUSY) ? (NCH'(1) << own_d) : '0;
    arb_err_d = arb_err_q | (|(bus.en & ~grant_q));
    rd_in     = (acc && !sel_we) ? grant_q : '0;
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q   <= IDLE;
      own_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      arb_err_q <= 1'b0;
      for (int i = 0; i < RAM_RL; i++) rd_pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      arb_err_q <= arb_err_d;
      for (int i = RAM_RL - 1; i > 0; i--) rd_pipe_q[i] <= rd_pipe_q[i-1];
      rd_pipe_q[0] <= rd_in;
    end
  end

  // RAM port: one mux level off the registered grant
  assign bus.RAM_CEN = ~acc;
  assign bus.RAM_WEN = (acc && sel_we) ? ~sel_wstrb : '1;
  assign bus.RAM_A   = acc ? sel_addr  : '0;
  assign bus.RAM_D   = acc ? sel_wdata : '0;
  assign bus.rdata   = bus.RAM_Q;
  assign bus.grant   = grant_q;
  assign bus.rvalid  = rd_pipe_q[RAM_RL-1];
  assign bus.arb_err = arb_err_q;
endmodule

// File: tb/tb_asi_ram_arb.sv
// Directed bench for asi_ram_arb: fixed/guard/RL=3 instance plus a round-robin instance.
module tb_asi_ram_arb;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  asi_ram_arb_if #(.NCH(4)) fif ();
  asi_ram_arb_if #(.NCH(4)) rif ();

  asi_ram_arb #(.NCH(4), .ARB_MODE(0), .MAX_BURSTS(2), .RAM_RL(3)) u_fix (
    .usr_clk(clk), .usr_reset_n(rst_n), .bus(fif));
  asi_ram_arb #(.NCH(4), .ARB_MODE(1), .MAX_BURSTS(0), .RAM_RL(1)) u_rr (
    .usr_clk(clk), .usr_reset_n(rst_n), .bus(rif));

  // Read-latency-3 RAM model returning an address-derived pattern
  logic [127:0] fq0, fq1, fq2;
  always_ff @(posedge clk) begin
    fq0 <= (!fif.RAM_CEN && (&fif.RAM_WEN)) ? {4{fif.RAM_A ^ 32'h5A5A0000}} : '0;
    fq1 <= fq0;
    fq2 <= fq1;
  end
  assign fif.RAM_Q = fq2;
  assign rif.RAM_Q = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fix();
    fif.en = '0; fif.we = '0; fif.last = '0;
    fif.addr = '0; fif.wdata = '0; fif.wstrb = '0;
  endtask

  task automatic set_fix(input int ch, input logic w, input logic l,
                         input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
    fif.en[ch]              = 1'b1;
    fif.we[ch]              = w;
    fif.last[ch]            = l;
    fif.addr[ch*32 +: 32]   = a;
    fif.wdata[ch*128 +: 128] = d;
    fif.wstrb[ch*16 +: 16]  = s;
  endtask

  logic [3:0] gexp [6];
  logic [3:0] g;

  initial begin
    rst_n = 1'b0;
    fif.req = '0; clr_fix();
    rif.req = '0; rif.en = '0; rif.we = '0; rif.last = '0;
    rif.addr = '0; rif.wdata = '0; rif.wstrb = '0;
    gexp[0] = 4'b0001; gexp[1] = 4'b0001; gexp[2] = 4'b1000;
    gexp[3] = 4'b0001; gexp[4] = 4'b0001; gexp[5] = 4'b1000;

    repeat (2) tick();
    check("rst_grant",   fif.grant,   4'b0000);
    check("rst_rvalid",  fif.rvalid,  4'b0000);
    check("rst_arb_err", fif.arb_err, 1'b0);
    check("rst_cen",     fif.RAM_CEN, 1'b1);
    check("rst_wen",     fif.RAM_WEN, 16'hFFFF);
    check("rst_a",       fif.RAM_A,   32'h0);
    check("rst_d",       fif.RAM_D,   128'h0);
    check("rst_rr_grant", rif.grant,  4'b0000);
    rst_n = 1'b1;

    // Fixed priority: ch1 wins over ch2, 4-beat burst ending in a read of 0x40
    tick(); fif.req = 4'b0110;
    tick(); check("g_first", fif.grant, 4'b0010);
    set_fix(1, 1'b1, 1'b0, 32'h100, 128'h1, 16'hFFFF); #1;
    check("beat1_cen", fif.RAM_CEN, 1'b0);
    tick(); check("beat2_grant", fif.grant, 4'b0010);
    set_fix(1, 1'b1, 1'b0, 32'h110, 128'h2, 16'hFFFF);
    tick(); check("beat3_grant", fif.grant, 4'b0010);
    set_fix(1, 1'b1, 1'b0, 32'h120, 128'h3, 16'hFFFF);
    tick(); check("beat4_grant", fif.grant, 4'b0010);
    set_fix(1, 1'b0, 1'b1, 32'h40, 128'h0, 16'h0000); fif.req = 4'b0100; #1;
    check("rd_cen", fif.RAM_CEN, 1'b0);
    check("rd_wen", fif.RAM_WEN, 16'hFFFF);
    check("rd_a",   fif.RAM_A,   32'h40);

    // Handoff to ch2 with no gap; partial-strobe write; stray en from ch0
    tick(); clr_fix();
    check("g_handoff", fif.grant,  4'b0100);
    check("rv_c5",     fif.rvalid, 4'b0000);
    set_fix(2, 1'b1, 1'b0, 32'h200, 128'h00112233445566778899AABBCCDDEEFF, 16'h00FF);
    fif.en[0] = 1'b1; #1;
    check("wr_cen", fif.RAM_CEN, 1'b0);
    check("wr_wen", fif.RAM_WEN, 16'hFF00);
    check("wr_a",   fif.RAM_A,   32'h200);
    check("wr_d",   fif.RAM_D,   128'h00112233445566778899AABBCCDDEEFF);
    tick(); clr_fix();
    check("arb_err_set", fif.arb_err, 1'b1);
    check("rv_c6",       fif.rvalid,  4'b0000);
    set_fix(2, 1'b1, 1'b1, 32'h210, 128'h5, 16'hFFFF); fif.req = 4'b0000;
    tick(); clr_fix();
    check("rv_c7",       fif.rvalid,  4'b0010);
    check("rdata_c7",    fif.rdata,   128'h5A5A0040_5A5A0040_5A5A0040_5A5A0040);
    check("g_idle",      fif.grant,   4'b0000);
    check("arb_err_hold", fif.arb_err, 1'b1);
    tick(); check("rv_c8", fif.rvalid, 4'b0000);

    // Starvation guard, MAX_BURSTS=2: 0,0,3,0,0,3
    fif.req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("guard_%0d", i), fif.grant, gexp[i]);
      g = gexp[i];
      fif.en = g; fif.last = g; fif.we = g;
    end
    tick(); clr_fix();
    check("guard_6", fif.grant, 4'b0001);

    // Round-robin: 0,1,2,3,0 with 1-beat bursts, then resume after IDLE from ptr
    rif.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      g = 4'b0001 << (i % 4);
      check($sformatf("rr_%0d", i), rif.grant, g);
      rif.en = g; rif.last = g; rif.we = g;
      if (i == 4) rif.req = 4'b0000;
    end
    tick(); rif.en = '0; rif.last = '0; rif.we = '0;
    check("rr_idle", rif.grant, 4'b0000);
    rif.req = 4'b0101;
    tick(); check("rr_ptr", rif.grant, 4'b0100);
    rif.req = 4'b0000;

    // Mid-burst reset with two reads in flight from ch0
    set_fix(0, 1'b0, 1'b0, 32'h80, 128'h0, 16'h0);
    tick(); set_fix(0, 1'b0, 1'b0, 32'h90, 128'h0, 16'h0);
    tick(); #1 rst_n = 1'b0; #1;
    check("mrst_grant",  fif.grant,   4'b0000);
    check("mrst_cen",    fif.RAM_CEN, 1'b1);
    check("mrst_rvalid", fif.rvalid,  4'b0000);
    clr_fix(); fif.req = 4'b0000;
    tick(); tick(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("post_rv_%0d", i), fif.rvalid, 4'b0000);
      check($sformatf("post_g_%0d", i),  fif.grant,  4'b0000);
    end
    fif.req = 4'b0010;
    tick(); check("post_idle_grant", fif.grant, 4'b0010);
    check("post_arb_err", fif.arb_err, 1'b0);
    fif.req = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
